ram_1c_dxw_rwrw_be: RTL and testbench
=====================================

# ram_1c_dxw_rwrw_be

Single-clock true dual-port RAM with per-byte write enables, a selectable read-during-write mode, an optional output pipeline stage and deterministic cross-port collision rules. Both ports may read or write every cycle. An optional post-reset clear engine zeroes the whole array. It is the general-purpose successor to the dual-port RAM primitives, for register files, caches and shared buffers inside a single clock domain.

## Interface
Parameters:
- DEPTH, 512: number of words; any value ≥ 2, not necessarily a power of two.
- WIDTH, 32: word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: lane width; the number of lanes NB = WIDTH/BYTE_WIDTH.
- READ_BEFORE_WRITE, 0: same-port read-during-write. 0 returns the new (merged) word; 1 returns the old word.
- OUTPUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving read latency 2.

Ports (AW = $clog2(DEPTH)):
- clock  in  1  single clock; all logic is on the rising edge.
- reset_  in  1  synchronous, active-low reset.
- busy  out  1  high while the clear engine runs; tied 0 when the engine is compiled out.
- address_a  in  AW  port A word address.
- wren_a  in  1  port A write strobe.
- byteena_a  in  NB  port A lane enables; only qualify the write when wren_a=1.
- data_a  in  WIDTH  port A write data.
- q_a  out  WIDTH  port A read data.
- address_b, wren_b, byteena_b, data_b, q_b: the same as port A, for port B.

## Operation
- Every cycle each port reads the word at its address. When wren=1, the lanes with byteena=1 are updated and the other lanes are untouched.
- **Same-port read-during-write:**
  - With READ_BEFORE_WRITE=0, q is the merged word: new data in enabled lanes, old data in disabled lanes.
  - With READ_BEFORE_WRITE=1, q is the pre-write word.
- **Cross-port read of an address being written in the same cycle:** always returns the old word, regardless of READ_BEFORE_WRITE. A read one cycle later returns the new word.
- **Both ports write the same address in the same cycle:**
  - Port A wins on each lane enabled by both ports.
  - Lanes enabled by only one port take that port's data.
  - The merged result is what each port's own q shows when READ_BEFORE_WRITE=0.
- **Out-of-range address (address ≥ DEPTH):** the write is dropped and the read returns 0.
- **Reset:**
  - q_a, q_b and the output-register stage clear to 0.
  - Array contents are unaffected unless the clear engine is compiled in.
  - busy is 1 during reset only with the engine compiled in; otherwise it is 0.

## Timing
- The address, write strobe, lane enables and data are sampled at edge N.
- With OUTPUT_REG=0, q is valid after edge N+1. With OUTPUT_REG=1, q is valid after edge N+2.
- Back-to-back accesses are fully pipelined: one access per port per cycle.
- **Clear-engine FSM** (when compiled in), with states CLEAR and READY:
  - While reset_=0: the state is CLEAR, the counter is 0 and busy=1.
  - In CLEAR with reset_=1: each cycle writes 0 to word `counter`, then increments the counter.
  - After word DEPTH-1 is written, the FSM moves to READY and busy falls on the next edge. The sweep takes exactly DEPTH cycles after reset_ rises.
  - While busy=1, port writes are ignored and q_a/q_b are forced to 0.
  - Reset asserted mid-clear restarts the sweep at word 0.
  - READY is held until the next reset.

## Configuration
- Macro: RAM_1C_CLEAR_ON_RESET_EN.
- **Defined:** the clear-engine FSM and counter are built. busy behaves as described under Timing, and the array is all-zero when busy falls.
- **Undefined:** no FSM and no counter. busy is constant 0, ports are usable in the first cycle after reset, and initial array contents are undefined (X in simulation).

## Test plan
- **Byte-lane write:** DEPTH=512, WIDTH=32. Write 0x11223344 to address 5 on port A. Then write address 5 with byteena_a=4'b0010 and data 0xAABBCCDD. Read address 5: q_a=0x1122CC44.
- **Same-port read-during-write:** word 7 holds 0x0. Port A writes 0xDEADBEEF to address 7. q_a=0xDEADBEEF when READ_BEFORE_WRITE=0, and 0x00000000 when READ_BEFORE_WRITE=1. Repeat with OUTPUT_REG=1 and check the data appears one cycle later.
- **Cross-port collision:**
  - Word 9 holds 0x0. A writes 0x000000FF with byteena 4'b0001. B writes 0x0000FF00 with byteena 4'b0011, both to address 9 in the same cycle.
  - Next read of address 9 returns 0x0000FFFF: lane 0 from A, lane 1 from B.
  - A port-B read of address 9 in the write cycle alone returns 0x0.
- **Out-of-range address:** DEPTH=300. A write to address 400 is dropped; a read of address 400 returns 0; word 144 (=400 mod 256) is unchanged.
- **Clear engine:** with the macro defined and DEPTH=16:
  - Release reset_: busy stays 1 for 16 cycles, then 0. All words read 0.
  - A write attempted while busy=1 has no effect.
  - Reassert reset_ at sweep cycle 8: after release, busy lasts 16 cycles again.
- **Reset of outputs:** pulse reset_ low for one edge mid-traffic. q_a and q_b are 0 on the next cycle, and array words written before the reset keep their values when the macro is undefined.

Source files
------------

// File: rtl/ram_1c_dxw_rwrw_be.sv
// Single-clock true dual-port RAM with byte-lane writes, port-A-wins collisions and optional output register.
// Define RAM_1C_CLEAR_ON_RESET_EN to build the post-reset clear engine that zeroes the array.

// Per-lane read-during-write merge: what each port sees of the lane when it writes it.
module ram_1c_dxw_rwrw_be_lane #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] old_a_i,
  input  logic [BW-1:0] old_b_i,
  input  logic          wl_a_i,
  input  logic          wl_b_i,
  input  logic          same_i,
  input  logic [BW-1:0] data_a_i,
  input  logic [BW-1:0] data_b_i,
  output logic [BW-1:0] mrg_a_o,
  output logic [BW-1:0] mrg_b_o
);
  // Port A owns a lane both ports enable, so B's view is overridden by A too.
  assign mrg_a_o = wl_a_i           ? data_a_i :
                   (same_i & wl_b_i) ? data_b_i : old_a_i;
  assign mrg_b_o = (same_i & wl_a_i) ? data_a_i :
                   wl_b_i            ? data_b_i : old_b_i;
endmodule

module ram_1c_dxw_rwrw_be #(
  parameter  int DEPTH             = 512,
  parameter  int WIDTH             = 32,
  parameter  int BYTE_WIDTH        = 8,
  parameter  int READ_BEFORE_WRITE = 0,
  parameter  int OUTPUT_REG        = 0,
  localparam int NB                = WIDTH / BYTE_WIDTH,
  localparam int AW                = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_,
  output logic             busy,
  input  logic [AW-1:0]    address_a,
  input  logic             wren_a,
  input  logic [NB-1:0]    byteena_a,
  input  logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] q_a,
  input  logic [AW-1:0]    address_b,
  input  logic             wren_b,
  input  logic [NB-1:0]    byteena_b,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] q_b
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          busy_int;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

`ifdef RAM_1C_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, READY} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = reset_;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH-1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign clr_addr = cnt_q;
  assign busy_int = (state_q == CLEAR) | ~reset_;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign busy_int = 1'b0;
`endif

  assign busy = busy_int;

  logic          inr_a, inr_b, we_a, we_b, same;
  logic [NB-1:0] wl_a, wl_b;

  assign inr_a = {1'b0, address_a} < DEPTH_W;
  assign inr_b = {1'b0, address_b} < DEPTH_W;
  assign we_a  = wren_a & inr_a & reset_ & ~busy_int;
  assign we_b  = wren_b & inr_b & reset_ & ~busy_int;
  assign same  = address_a == address_b;
  assign wl_a  = {NB{we_a}} & byteena_a;
  assign wl_b  = {NB{we_b}} & byteena_b;

  logic [WIDTH-1:0] old_a, old_b, mrg_a, mrg_b;

  assign old_a = inr_a ? mem[address_a] : '0;
  assign old_b = inr_b ? mem[address_b] : '0;

  for (genvar l = 0; l < NB; l++) begin : g_lane
    ram_1c_dxw_rwrw_be_lane #(.BW(BYTE_WIDTH)) u_lane (
      .old_a_i  (old_a[l*BYTE_WIDTH +: BYTE_WIDTH]),
      .old_b_i  (old_b[l*BYTE_WIDTH +: BYTE_WIDTH]),
      .wl_a_i   (wl_a[l]),
      .wl_b_i   (wl_b[l]),
      .same_i   (same),
      .data_a_i (data_a[l*BYTE_WIDTH +: BYTE_WIDTH]),
      .data_b_i (data_b[l*BYTE_WIDTH +: BYTE_WIDTH]),
      .mrg_a_o  (mrg_a[l*BYTE_WIDTH +: BYTE_WIDTH]),
      .mrg_b_o  (mrg_b[l*BYTE_WIDTH +: BYTE_WIDTH])
    );
  end

  // B is written first so A's assignment lands last on shared lanes.
  always_ff @(posedge clock) begin
    if (clr_we) mem[clr_addr] <= '0;
    for (int l = 0; l < NB; l++) begin
      if (wl_b[l]) mem[address_b][l*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[l*BYTE_WIDTH +: BYTE_WIDTH];
      if (wl_a[l]) mem[address_a][l*BYTE_WIDTH +: BYTE_WIDTH] <= data_a[l*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  logic [WIDTH-1:0] rd_a_d, rd_b_d, rd_a_q, rd_b_q;

  // Cross-port reads always see the pre-write word; only the writing port may see the merge.
  always_comb begin
    rd_a_d = old_a;
    rd_b_d = old_b;
    if (READ_BEFORE_WRITE == 0) begin
      if (we_a) rd_a_d = mrg_a;
      if (we_b) rd_b_d = mrg_b;
    end
    if (busy_int) begin
      rd_a_d = '0;
      rd_b_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] out_a_q, out_b_q;
    always_ff @(posedge clock) begin
      if (!reset_) begin
        out_a_q <= '0;
        out_b_q <= '0;
      end else begin
        out_a_q <= rd_a_q;
        out_b_q <= rd_b_q;
      end
    end
    assign q_a = out_a_q;
    assign q_b = out_b_q;
  end else begin : g_noreg
    assign q_a = rd_a_q;
    assign q_b = rd_b_q;
  end

endmodule

// File: tb/tb_ram_1c_dxw_rwrw_be.sv
// Randomized scoreboard bench for ram_1c_dxw_rwrw_be: two instances (RBW=0/lat 1, RBW=1/lat 2) share stimulus.
// Honours RAM_1C_CLEAR_ON_RESET_EN when the design is built with the clear engine.
module tb_ram_1c_dxw_rwrw_be;
  localparam int DEPTH = 300;
  localparam int NB    = 4;

  logic        clock  = 1'b0;
  logic        reset_ = 1'b0;
  logic [8:0]  address_a = '0, address_b = '0;
  logic        wren_a = 1'b0, wren_b = 1'b0;
  logic [3:0]  byteena_a = '0, byteena_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [31:0] q_a0, q_b0, q_a1, q_b1;
  logic        busy0, busy1;

  always #5 clock = ~clock;

  ram_1c_dxw_rwrw_be #(.DEPTH(DEPTH), .WIDTH(32), .BYTE_WIDTH(8),
                       .READ_BEFORE_WRITE(0), .OUTPUT_REG(0)) u0 (
    .clock(clock), .reset_(reset_), .busy(busy0),
    .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a), .q_a(q_a0),
    .address_b(address_b), .wren_b(wren_b), .byteena_b(byteena_b), .data_b(data_b), .q_b(q_b0));

  ram_1c_dxw_rwrw_be #(.DEPTH(DEPTH), .WIDTH(32), .BYTE_WIDTH(8),
                       .READ_BEFORE_WRITE(1), .OUTPUT_REG(1)) u1 (
    .clock(clock), .reset_(reset_), .busy(busy1),
    .address_a(address_a), .wren_a(wren_a), .byteena_a(byteena_a), .data_a(data_a), .q_a(q_a1),
    .address_b(address_b), .wren_b(wren_b), .byteena_b(byteena_b), .data_b(data_b), .q_b(q_b1));

  typedef struct {
    int          due;
    logic [31:0] qa, qb, ma, mb;
  } exp_t;

  exp_t        sb0[$], sb1[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  int          sweep_left = 0;
  logic [31:0] mdl [DEPTH];
  logic [3:0]  kn  [DEPTH];   // lanes whose content the model knows

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] lmask(input logic [3:0] k);
    logic [31:0] m;
    for (int l = 0; l < NB; l++) m[l*8 +: 8] = {8{k[l]}};
    return m;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] msk);
    if (msk == 32'h0) return;
    n_chk++;
    if ((act & msk) !== (exp & msk)) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h (lane mask %h)", nm, cyc, act, exp, msk);
    end
  endtask

  // Monitor: pops expectations when their cycle arrives.
  always @(negedge clock) begin : mon
    exp_t e;
    while (sb0.size() > 0 && sb0[0].due <= cyc) begin
      e = sb0.pop_front();
      if (e.due == cyc) begin
        check("u0.q_a", q_a0, e.qa, e.ma);
        check("u0.q_b", q_b0, e.qb, e.mb);
      end else check("u0.stale_entry", 32'(e.due), 32'(cyc), 32'hFFFF_FFFF);
    end
    while (sb1.size() > 0 && sb1[0].due <= cyc) begin
      e = sb1.pop_front();
      if (e.due == cyc) begin
        check("u1.q_a", q_a1, e.qa, e.ma);
        check("u1.q_b", q_b1, e.qb, e.mb);
      end else check("u1.stale_entry", 32'(e.due), 32'(cyc), 32'hFFFF_FFFF);
    end
  end

  // One cycle of traffic on both ports; model derives every expected word from the access rules.
  task automatic op(input logic [8:0] aa, input logic wa, input logic [3:0] ba, input logic [31:0] da,
                    input logic [8:0] ab, input logic wb, input logic [3:0] bb, input logic [31:0] db,
                    input bit chk = 1'b1);
    logic        bz, ia, ib, wea, web;
    logic [31:0] oa, ob, na, nb;
    logic [3:0]  ka, kb, nka, nkb;
    exp_t        e0, e1;
    bz = (sweep_left != 0);
    check("busy0", {31'b0, busy0}, {31'b0, bz}, 32'h1);
    check("busy1", {31'b0, busy1}, {31'b0, bz}, 32'h1);
    ia  = int'(aa) < DEPTH;
    ib  = int'(ab) < DEPTH;
    oa  = ia ? mdl[aa] : 32'h0;
    ob  = ib ? mdl[ab] : 32'h0;
    ka  = ia ? kn[aa] : 4'hF;
    kb  = ib ? kn[ab] : 4'hF;
    wea = wa && ia && !bz;
    web = wb && ib && !bz;
    na = oa; nka = ka; nb = ob; nkb = kb;
    for (int l = 0; l < NB; l++) begin
      if (web && ab == aa && bb[l]) begin na[l*8 +: 8] = db[l*8 +: 8]; nka[l] = 1'b1; end
      if (wea && ba[l])             begin na[l*8 +: 8] = da[l*8 +: 8]; nka[l] = 1'b1; end
      if (web && bb[l])             begin nb[l*8 +: 8] = db[l*8 +: 8]; nkb[l] = 1'b1; end
      if (wea && aa == ab && ba[l]) begin nb[l*8 +: 8] = da[l*8 +: 8]; nkb[l] = 1'b1; end
    end
    e0.due = cyc + 1;
    e0.qa  = bz ? 32'h0 : (wea ? na : oa);
    e0.qb  = bz ? 32'h0 : (web ? nb : ob);
    e0.ma  = !chk ? 32'h0 : bz ? 32'hFFFF_FFFF : lmask(wea ? nka : ka);
    e0.mb  = !chk ? 32'h0 : bz ? 32'hFFFF_FFFF : lmask(web ? nkb : kb);
    e1.due = cyc + 2;
    e1.qa  = bz ? 32'h0 : oa;
    e1.qb  = bz ? 32'h0 : ob;
    e1.ma  = !chk ? 32'h0 : bz ? 32'hFFFF_FFFF : lmask(ka);
    e1.mb  = !chk ? 32'h0 : bz ? 32'hFFFF_FFFF : lmask(kb);
    sb0.push_back(e0);
    sb1.push_back(e1);
    if (ia) begin mdl[aa] = na; kn[aa] = nka; end
    if (ib) begin mdl[ab] = nb; kn[ab] = nkb; end
    address_a = aa; wren_a = wa; byteena_a = ba; data_a = da;
    address_b = ab; wren_b = wb; byteena_b = bb; data_b = db;
    @(posedge clock); #1;
    if (sweep_left > 0) sweep_left--;
  endtask

  task automatic rst(input int n);
    exp_t e;
    logic bexp;
`ifdef RAM_1C_CLEAR_ON_RESET_EN
    bexp = 1'b1;
`else
    bexp = 1'b0;
`endif
    reset_ = 1'b0; wren_a = 1'b0; wren_b = 1'b0;
    #1;
    check("busy_in_reset", {31'b0, busy0}, {31'b0, bexp}, 32'h1);
    for (int i = 0; i < n; i++) begin
      e.qa = 32'h0; e.qb = 32'h0; e.ma = 32'hFFFF_FFFF; e.mb = 32'hFFFF_FFFF;
      e.due = cyc + 1; sb0.push_back(e);
      e.due = cyc + 2; sb1.push_back(e);
      @(posedge clock); #1;
    end
    reset_ = 1'b1;
`ifdef RAM_1C_CLEAR_ON_RESET_EN
    sweep_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = 32'h0; kn[i] = 4'hF; end
`endif
  endtask

  function automatic logic [8:0] ra();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 9'($urandom_range(DEPTH, 511));
    if (r < 3)  return 9'($urandom_range(0, DEPTH-1));
    return 9'($urandom_range(0, 7));
  endfunction

  task automatic rand_op(input bit chk = 1'b1);
    logic [8:0] aa, ab;
    aa = ra();
    ab = ($urandom_range(0, 3) == 0) ? aa : ra();
    op(aa, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
       ab, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(), chk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = 32'h0; kn[i] = 4'h0; end
    rst(2);
`ifdef RAM_1C_CLEAR_ON_RESET_EN
    // Writes during the sweep are ignored; restart mid-sweep, then run a full one.
    for (int i = 0; i < 8; i++) rand_op();
    rst(1);
    for (int i = 0; i < DEPTH; i++) rand_op();
`endif
    for (int i = 0; i < DEPTH; i += 2)
      op(9'(i), 1'b1, 4'hF, $urandom(), 9'(i+1), 1'b1, 4'hF, $urandom());

    op(9'd5, 1'b1, 4'hF,    32'h1122_3344, 9'd5, 1'b0, 4'h0, 32'h0);
    op(9'd5, 1'b1, 4'b0010, 32'hAABB_CCDD, 9'd6, 1'b0, 4'h0, 32'h0);
    op(9'd5, 1'b0, 4'h0,    32'h0,         9'd5, 1'b0, 4'h0, 32'h0);
    op(9'd7, 1'b1, 4'hF,    32'h0,         9'd0, 1'b0, 4'h0, 32'h0);
    op(9'd7, 1'b1, 4'hF,    32'hDEAD_BEEF, 9'd7, 1'b0, 4'h0, 32'h0);
    op(9'd7, 1'b0, 4'h0,    32'h0,         9'd7, 1'b0, 4'h0, 32'h0);
    op(9'd9, 1'b1, 4'hF,    32'h0,         9'd1, 1'b0, 4'h0, 32'h0);
    op(9'd9, 1'b1, 4'b0001, 32'h0000_00FF, 9'd9, 1'b1, 4'b0011, 32'h0000_FF00);
    op(9'd9, 1'b0, 4'h0,    32'h0,         9'd9, 1'b0, 4'h0, 32'h0);
    op(9'd9, 1'b1, 4'hF,    32'h1234_5678, 9'd9, 1'b0, 4'h0, 32'h0);
    op(9'd400, 1'b1, 4'hF,  32'hCAFE_F00D, 9'd400, 1'b0, 4'h0, 32'h0);
    op(9'd144, 1'b0, 4'h0,  32'h0,         9'd400, 1'b0, 4'h0, 32'h0);

    for (int i = 0; i < 800; i++) rand_op();

    // Reset mid-traffic: previously written words survive unless the clear engine is built.
    rand_op(1'b0);
    rst(1);
`ifdef RAM_1C_CLEAR_ON_RESET_EN
    for (int i = 0; i < DEPTH; i++) rand_op();
`endif
    for (int i = 0; i < 200; i++) rand_op();

    address_a = 9'd0; address_b = 9'd0; wren_a = 1'b0; wren_b = 1'b0;
    for (int i = 0; i < 10 && (sb0.size() + sb1.size()) != 0; i++) begin
      @(negedge clock); #1;
    end
    check("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'h0, 32'hFFFF_FFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
